// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared types and constants for the immediate extension unit
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_ZERO  = 2'b00,
    IMM_SIGN  = 2'b01,
    IMM_ONES  = 2'b10,
    IMM_UPPER = 2'b11
  } imm_mode_t;

  localparam int IMM_Q_DEPTH = 2;
  localparam int IMM_STAT_W  = 16;

  // Counters hold at all-ones rather than wrapping back to zero.
  function automatic logic [IMM_STAT_W-1:0] sat_inc(input logic [IMM_STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// rtl/imm_ext_core.sv - combinational extend and clamped left-shift datapath
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int SHIFT_MAX = 3,
  localparam int SH_W     = (SHIFT_MAX > 0) ? $clog2(SHIFT_MAX + 1) : 1
) (
  input  logic [IN_W-1:0]  imm_i,
  input  imm_mode_t        mode_i,
  input  logic [SH_W-1:0]  shamt_i,
  output logic [OUT_W-1:0] ext_o
);

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_ext_core: IN_W must be at least 2");
  end
  if (OUT_W < IN_W + SHIFT_MAX) begin : g_bad_out_w
    $error("imm_ext_core: OUT_W must be at least IN_W + SHIFT_MAX");
  end

  localparam logic [SH_W-1:0] SH_LIMIT = SH_W'(SHIFT_MAX);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] fill;
  logic [SH_W-1:0]  shamt_eff;

  always_comb begin
    zext      = OUT_W'(imm_i);
    shamt_eff = (shamt_i > SH_LIMIT) ? SH_LIMIT : shamt_i;
    fill      = zext;
    unique case (mode_i)
      IMM_ZERO:  fill = zext;
      IMM_SIGN:  fill = OUT_W'($signed(imm_i));
      IMM_ONES:  fill = ({OUT_W{1'b1}} << IN_W) | zext;
      IMM_UPPER: fill = zext << (OUT_W - IN_W);
      default:   fill = zext;
    endcase
    // Upper-place already positions the field at the top, so the shift is skipped.
    ext_o = (mode_i == IMM_UPPER) ? fill : (fill << shamt_eff);
  end

endmodule

// File: rtl/imm_ext_unit.sv
// rtl/imm_ext_unit.sv - buffered immediate extender; IMM_EXT_STATS_EN enables stat counters
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int SHIFT_MAX = 3,
  localparam int SH_W     = (SHIFT_MAX > 0) ? $clog2(SHIFT_MAX + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [1:0]            in_mode,
  input  logic [SH_W-1:0]       in_shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_imm,
  output logic [IMM_STAT_W-1:0] stat_acc,
  output logic [IMM_STAT_W-1:0] stat_stall
);

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] mem_q [IMM_Q_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push;
  logic             pop;

  imm_ext_core #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .SHIFT_MAX (SHIFT_MAX)
  ) u_core (
    .imm_i   (in_imm),
    .mode_i  (imm_mode_t'(in_mode)),
    .shamt_i (in_shamt),
    .ext_o   (ext)
  );

  assign in_ready  = rst_n && (count_q < 2'(IMM_Q_DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign out_imm   = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: out_imm is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ext;
    end
  end

`ifdef IMM_EXT_STATS_EN
  logic [IMM_STAT_W-1:0] acc_q, acc_d;
  logic [IMM_STAT_W-1:0] stall_q, stall_d;

  always_comb begin
    acc_d   = push ? sat_inc(acc_q) : acc_q;
    stall_d = (out_valid && !out_ready) ? sat_inc(stall_q) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      acc_q   <= acc_d;
      stall_q <= stall_d;
    end
  end

  assign stat_acc   = acc_q;
  assign stat_stall = stall_q;
`else
  assign stat_acc   = '0;
  assign stat_stall = '0;
`endif

endmodule
